// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer slice.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'b00,
        MODE_CHASE  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Position width: clog2 of the channel count, never narrower than one bit.
    function automatic int pos_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_seq_if.sv
// Control/status bundle between a host (master) and led_sequencer (slave).
// When LED_SEQ_PWM_EN is defined the bundle also carries the 4-bit duty input.
interface led_seq_if #(
    parameter int N_LEDS = 4,
    parameter int CNT_W  = 32
);
    import led_seq_pkg::*;

    localparam int POS_W = pos_width(N_LEDS);

    logic              en;
    logic [1:0]        mode;
    logic              dir;
    logic [CNT_W-1:0]  limit;
    logic              load;
`ifdef LED_SEQ_PWM_EN
    logic [3:0]        duty;
`endif
    logic [N_LEDS-1:0] leds;
    logic [POS_W-1:0]  pos;
    logic              wrap;

    modport master (
        output en, mode, dir, limit, load,
`ifdef LED_SEQ_PWM_EN
        output duty,
`endif
        input  leds, pos, wrap
    );

    modport slave (
        input  en, mode, dir, limit, load,
`ifdef LED_SEQ_PWM_EN
        input  duty,
`endif
        output leds, pos, wrap
    );

endinterface

// File: rtl/led_tick_gen.sv
// Step prescaler: holds the programmable period and emits one tick every
// limit_q enabled clocks. A load or a clear restarts the count and drops
// any tick that would have fired in that cycle.
module led_tick_gen #(
    parameter int CNT_W         = 32,
    parameter int DEFAULT_LIMIT = 500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] limit,
    input  logic             clr,
    output logic             tick
);

    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] cnt;
    logic             at_end;

    // Periods of 0 and 1 both mean "every enabled cycle".
    assign at_end = (limit_q <= CNT_W'(1)) || (cnt == limit_q - CNT_W'(1));
    assign tick   = en && at_end && !load && !clr;

    // Period register and free count; load/clear win over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            limit_q <= CNT_W'(DEFAULT_LIMIT);
            cnt     <= '0;
        end else begin
            if (load)
                limit_q <= limit;
            if (load || clr)
                cnt <= '0;
            else if (en)
                cnt <= at_end ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// N-channel LED pattern generator (toggle / chase / bounce / fill).
// Optional build macro LED_SEQ_PWM_EN adds a 4-bit duty brightness gate.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_LEDS        = 4,
    parameter int CNT_W         = 32,
    parameter int DEFAULT_LIMIT = 500_000
) (
    input logic     clk,
    input logic     rst,
    led_seq_if.slave bus
);

    localparam int POS_W = pos_width(N_LEDS);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

    mode_e             mode_q;
    logic [POS_W-1:0]  pos_q, pos_nx;
    logic [N_LEDS-1:0] leds_q, leds_nx;
    logic              bdir, bdir_nx;
    logic              wrap_q, wrap_nx;
    logic              mode_chg;
    logic              tick;
    logic              at_max, at_min;
    logic [POS_W-1:0]  pos_inc, pos_dec, pos_dir;

    assign mode_chg = (mode_e'(bus.mode) != mode_q);

    led_tick_gen #(
        .CNT_W         (CNT_W),
        .DEFAULT_LIMIT (DEFAULT_LIMIT)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .load  (bus.load),
        .limit (bus.limit),
        .clr   (mode_chg),
        .tick  (tick)
    );

    function automatic logic [N_LEDS-1:0] onehot(input logic [POS_W-1:0] p);
        return N_LEDS'(1) << p;
    endfunction

    function automatic logic [N_LEDS-1:0] fill_to(input logic [POS_W-1:0] p);
        logic [N_LEDS-1:0] f;
        for (int i = 0; i < N_LEDS; i++)
            f[i] = (i <= int'(p));
        return f;
    endfunction

    assign at_max  = (pos_q == POS_MAX);
    assign at_min  = (pos_q == '0);
    assign pos_inc = at_max ? '0 : pos_q + 1'b1;
    assign pos_dec = at_min ? POS_MAX : pos_q - 1'b1;
    assign pos_dir = (bus.dir == DIR_DOWN) ? pos_dec : pos_inc;

    // Next pattern state for a step in the current mode.
    always_comb begin
        pos_nx  = pos_q;
        leds_nx = leds_q;
        bdir_nx = bdir;
        wrap_nx = 1'b0;
        unique case (mode_q)
            MODE_TOGGLE: begin
                leds_nx = leds_q ^ onehot(pos_q);
                pos_nx  = pos_dir;
                wrap_nx = (bus.dir == DIR_DOWN) ? at_min : at_max;
            end
            MODE_CHASE: begin
                pos_nx  = pos_dir;
                leds_nx = onehot(pos_dir);
                wrap_nx = (bus.dir == DIR_DOWN) ? at_min : at_max;
            end
            MODE_BOUNCE: begin
                // Saturating move; reversal happens on arrival at an end.
                if (bdir == DIR_UP) begin
                    pos_nx  = at_max ? pos_q : pos_q + 1'b1;
                    wrap_nx = (pos_nx == POS_MAX);
                end else begin
                    pos_nx  = at_min ? pos_q : pos_q - 1'b1;
                    wrap_nx = (pos_nx == '0);
                end
                bdir_nx = wrap_nx ? ~bdir : bdir;
                leds_nx = onehot(pos_nx);
            end
            MODE_FILL: begin
                pos_nx  = pos_dir;
                leds_nx = fill_to(pos_dir);
                wrap_nx = (bus.dir == DIR_DOWN) ? at_min : at_max;
            end
            default: ;
        endcase
    end

    // Pattern registers: mode change restarts the pattern, else step on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= mode_e'(bus.mode);
            pos_q  <= '0;
            leds_q <= '0;
            bdir   <= DIR_UP;
            wrap_q <= 1'b0;
        end else if (mode_chg) begin
            mode_q <= mode_e'(bus.mode);
            pos_q  <= '0;
            leds_q <= '0;
            bdir   <= DIR_UP;
            wrap_q <= 1'b0;
        end else if (tick) begin
            pos_q  <= pos_nx;
            leds_q <= leds_nx;
            bdir   <= bdir_nx;
            wrap_q <= wrap_nx;
        end else begin
            wrap_q <= 1'b0;
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [3:0] pwm_cnt;

    // Free-running brightness counter, independent of en.
    always_ff @(posedge clk) begin
        if (rst)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign bus.leds = leds_q & {N_LEDS{pwm_cnt < bus.duty}};
`else
    assign bus.leds = leds_q;
`endif

    assign bus.pos  = pos_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer (N_LEDS=4, step period 3 then 1).
module tb_led_sequencer;
    import led_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    led_seq_if #(.N_LEDS(4), .CNT_W(32)) bus ();

    led_sequencer #(.N_LEDS(4), .CNT_W(32), .DEFAULT_LIMIT(500_000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Pattern register view (the ungated LED vector when PWM is built in).
    logic [3:0] leds_obs;
`ifdef LED_SEQ_PWM_EN
    assign leds_obs = dut.leds_q;
`else
    assign leds_obs = bus.leds;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full step period ending in a tick, then check pattern outputs.
    task automatic do_tick(input int gap, input string tag,
                           input logic [3:0] el, input logic [1:0] ep, input logic ew);
        step();
        if (gap > 1)
            chk({tag, "_wrap_clr"}, 32'(bus.wrap), 32'd0);
        for (int i = 1; i < gap; i++)
            step();
        chk({tag, "_leds"}, 32'(leds_obs), 32'(el));
        chk({tag, "_pos"},  32'(bus.pos),  32'(ep));
        chk({tag, "_wrap"}, 32'(bus.wrap), 32'(ew));
    endtask

    logic [3:0] tg_l [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                             4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [1:0] tg_p [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] ch_p [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    logic [1:0] bo_p [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
    logic [3:0] fi_l [5] = '{4'b0011, 4'b0111, 4'b1111, 4'b0001, 4'b0011};
    logic [1:0] fi_p [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.mode = MODE_TOGGLE;
        bus.dir  = DIR_UP;
        bus.limit = 32'd0;
        bus.load = 1'b0;
`ifdef LED_SEQ_PWM_EN
        bus.duty = 4'd15;
`endif
        step();
        step();
        rst = 1'b0;
        chk("rst_leds",  32'(leds_obs), 32'd0);
        chk("rst_pos",   32'(bus.pos),  32'd0);
        chk("rst_wrap",  32'(bus.wrap), 32'd0);
        chk("rst_limit", dut.u_tick.limit_q, 32'd500000);

        // Load period 3 and start running
        bus.en    = 1'b1;
        bus.load  = 1'b1;
        bus.limit = 32'd3;
        step();
        bus.load = 1'b0;
        chk("load_cnt", dut.u_tick.cnt, 32'd0);

        // TOGGLE, up
        for (int k = 0; k < 8; k++)
            do_tick(3, $sformatf("tog%0d", k + 1), tg_l[k], tg_p[k], (k == 3 || k == 7));

        // CHASE, down
        bus.mode = MODE_CHASE;
        bus.dir  = DIR_DOWN;
        step();
        chk("ch_enter_pos", 32'(bus.pos), 32'd0);
        for (int k = 0; k < 5; k++)
            do_tick(3, $sformatf("ch%0d", k + 1), 4'(4'b0001 << ch_p[k]), ch_p[k], (k == 0 || k == 4));

        // BOUNCE, dir input flipped mid-run
        bus.mode = MODE_BOUNCE;
        step();
        for (int k = 0; k < 7; k++) begin
            if (k == 3) bus.dir = DIR_UP;
            do_tick(3, $sformatf("bo%0d", k + 1), 4'(4'b0001 << bo_p[k]), bo_p[k], (k == 2 || k == 5));
        end

        // FILL, up
        bus.mode = MODE_FILL;
        bus.dir  = DIR_UP;
        step();
        for (int k = 0; k < 5; k++)
            do_tick(3, $sformatf("fi%0d", k + 1), fi_l[k], fi_p[k], (k == 3));

        // CHASE one step, then switch to FILL in the tick cycle
        bus.mode = MODE_CHASE;
        step();
        do_tick(3, "chx", 4'b0010, 2'd1, 1'b0);
        step();
        step();
        bus.mode = MODE_FILL;
        step();
        chk("mchg_pos",  32'(bus.pos),  32'd0);
        chk("mchg_leds", 32'(leds_obs), 32'd0);
        chk("mchg_cnt",  dut.u_tick.cnt, 32'd0);
        do_tick(3, "fx", 4'b0011, 2'd1, 1'b0);

        // Freeze with en=0
        bus.en = 1'b0;
        repeat (10) step();
        chk("frz_leds", 32'(leds_obs), 32'b0011);
        chk("frz_pos",  32'(bus.pos),  32'd1);
        chk("frz_cnt",  dut.u_tick.cnt, 32'd0);

        // Period 1: a tick every cycle
        bus.en    = 1'b1;
        bus.load  = 1'b1;
        bus.limit = 32'd1;
        step();
        bus.load = 1'b0;
        chk("ld1_pos", 32'(bus.pos), 32'd1);
        do_tick(1, "f1a", 4'b0111, 2'd2, 1'b0);
        do_tick(1, "f1b", 4'b1111, 2'd3, 1'b0);
        do_tick(1, "f1c", 4'b0001, 2'd0, 1'b1);

        // Reset mid-BOUNCE while moving down
        bus.mode = MODE_BOUNCE;
        step();
        do_tick(1, "rb1", 4'b0010, 2'd1, 1'b0);
        do_tick(1, "rb2", 4'b0100, 2'd2, 1'b0);
        do_tick(1, "rb3", 4'b1000, 2'd3, 1'b1);
        do_tick(1, "rb4", 4'b0100, 2'd2, 1'b0);
        chk("rb_bdir_dn", 32'(dut.bdir), 32'(DIR_DOWN));
        rst = 1'b1;
        step();
        chk("mrst_leds",  32'(leds_obs), 32'd0);
        chk("mrst_pos",   32'(bus.pos),  32'd0);
        chk("mrst_wrap",  32'(bus.wrap), 32'd0);
        chk("mrst_bdir",  32'(dut.bdir), 32'(DIR_UP));
        chk("mrst_limit", dut.u_tick.limit_q, 32'd500000);
        rst = 1'b0;

`ifdef LED_SEQ_PWM_EN
        begin
            int on_cnt;
            bus.load  = 1'b1;
            bus.limit = 32'd1;
            step();
            bus.load = 1'b0;
            step();
            bus.en   = 1'b0;
            bus.duty = 4'd4;
            step();
            on_cnt = 0;
            for (int i = 0; i < 16; i++) begin
                if (bus.leds != 4'd0) on_cnt++;
                step();
            end
            chk("pwm_on", 32'(on_cnt), 32'd4);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
